clreq_trk: RTL

CLREQ_TRK -- requirements
Module: clreq_trk

---
 rtl/clreq_pkg.sv | 10 +
 rtl/clreq_trk_mreg.sv | 30 +++
 rtl/clreq_trk.sv | 105 ++++++++++
 3 files changed

// File: rtl/clreq_pkg.sv
// rtl/clreq_pkg.sv - shared widths, depth and tag/sid types for the cache-line request tracker
package clreq_pkg;
    localparam int TAG_W  = 3;
    localparam int SID_W  = 3;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 1 << TAG_W;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [SID_W-1:0] sid_t;
endpackage

// File: rtl/clreq_trk_mreg.sv
// rtl/clreq_trk_mreg.sv - single-entry valid/payload output register, reloadable while draining
module clreq_trk_mreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    input  logic         rdy_i,
    output logic         v_o,
    output logic [W-1:0] q_o
);
    logic         v_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else if (ld_i) begin
            v_q    <= 1'b1;
            data_q <= d_i;
        end else if (rdy_i) begin
            v_q    <= 1'b0;
        end
    end

    assign v_o = v_q;
    assign q_o = data_q;
endmodule

// File: rtl/clreq_trk.sv
// rtl/clreq_trk.sv - tags cache-line reads, issues them to memory, retires completions in order
module clreq_trk
    import clreq_pkg::*;
#(
    parameter int tag_width  = TAG_W,
    parameter int sid_width  = SID_W,
    parameter int addr_width = ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clreq_v,
    output logic                  i_clreq_r,
    input  logic [sid_width-1:0]  i_clreq_sid,
    input  logic [addr_width-1:0] i_clreq_addr,
    output logic                  o_mreq_v,
    input  logic                  o_mreq_r,
    output logic [tag_width-1:0]  o_mreq_tag,
    output logic [addr_width-1:0] o_mreq_addr,
    input  logic                  i_mrsp_v,
    input  logic [tag_width-1:0]  i_mrsp_tag,
    output logic                  o_clrsp_v,
    input  logic                  o_clrsp_r,
    output logic [sid_width-1:0]  o_clrsp_sid,
    output logic                  o_err
);
    localparam int depth = 1 << tag_width;
    localparam logic [tag_width:0] full_cnt = (tag_width + 1)'(depth);

    logic [tag_width-1:0] head_q, tail_q, rsp_off;
    logic [tag_width:0]   cnt_q, cnt_d;
    logic [depth-1:0]     done_q, done_d;
    logic [sid_width-1:0] sid_q [depth];
    logic                 en_q, err_q;
    logic                 accept, retire, rsp_ok;
    logic [tag_width+addr_width-1:0] mreq_q;

    // en_q holds ready low until the first edge after reset release
    assign i_clreq_r   = en_q && (cnt_q != full_cnt) && (!o_mreq_v || o_mreq_r);
    assign accept      = i_clreq_v && i_clreq_r;
    assign o_clrsp_v   = (cnt_q != '0) && done_q[head_q];
    assign o_clrsp_sid = sid_q[head_q];
    assign retire      = o_clrsp_v && o_clrsp_r;
    assign o_err       = err_q;

    // a tag is live when its distance from head is below the outstanding count
    assign rsp_off = i_mrsp_tag - head_q;
    assign rsp_ok  = ({1'b0, rsp_off} < cnt_q) && !done_q[i_mrsp_tag];

    always_comb begin
        done_d = done_q;
        if (retire)
            done_d[head_q] = 1'b0;
        if (i_mrsp_v && rsp_ok)
            done_d[i_mrsp_tag] = 1'b1;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !retire)
            cnt_d = cnt_q + 1'b1;
        else if (!accept && retire)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            done_q <= '0;
            en_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            en_q   <= 1'b1;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            if (accept)
                tail_q <= tail_q + 1'b1;
            if (retire)
                head_q <= head_q + 1'b1;
            if (i_mrsp_v && !rsp_ok)
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            sid_q[tail_q] <= i_clreq_sid;
    end

    clreq_trk_mreg #(
        .W(tag_width + addr_width)
    ) u_mreg (
        .clk  (clk),
        .reset(reset),
        .ld_i (accept),
        .d_i  ({tail_q, i_clreq_addr}),
        .rdy_i(o_mreq_r),
        .v_o  (o_mreq_v),
        .q_o  (mreq_q)
    );

    assign o_mreq_tag  = mreq_q[tag_width+addr_width-1:addr_width];
    assign o_mreq_addr = mreq_q[addr_width-1:0];
endmodule
